// File: rtl/ram_port_arbiter.sv
// Round-robin two-port sequencer for a single-port RAM; one access per 3+RD_LATENCY cycles, GNT one cycle after REQ.
// Backpressure: a losing or late request simply waits (holding its command) until the arbiter returns to IDLE.
module ram_port_arbiter #(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_BITS  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 A_REQ,
    input  logic                 A_WE,
    input  logic [ADDR_BITS-1:0] A_ADDR,
    input  logic [DATA_BITS-1:0] A_WDATA,
    output logic                 A_GNT,
    output logic [DATA_BITS-1:0] A_RDATA,
    output logic                 A_VALID,
    input  logic                 B_REQ,
    input  logic                 B_WE,
    input  logic [ADDR_BITS-1:0] B_ADDR,
    input  logic [DATA_BITS-1:0] B_WDATA,
    output logic                 B_GNT,
    output logic [DATA_BITS-1:0] B_RDATA,
    output logic                 B_VALID,
    output logic [ADDR_BITS-1:0] RAM_ADDR,
    output logic [DATA_BITS-1:0] RAM_DATA_IN,
    output logic                 RAM_WRITE,
    input  logic [DATA_BITS-1:0] RAM_DATA_OUT
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = 3;

    state_t                 state_q, state_d;
    logic                   prio_q, prio_d;      // 0 = A preferred, 1 = B preferred
    logic                   owner_q, owner_d;    // 0 = A, 1 = B
    logic                   we_q, we_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   a_gnt_q, a_gnt_d;
    logic                   b_gnt_q, b_gnt_d;
    logic                   a_vld_q, a_vld_d;
    logic                   b_vld_q, b_vld_d;
    logic [DATA_BITS-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_BITS-1:0]   b_rdata_q, b_rdata_d;
    logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_BITS-1:0]   ram_din_q, ram_din_d;
    logic                   ram_wr_q, ram_wr_d;
    logic                   win_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_vld_q    <= a_vld_d;
            b_vld_q    <= b_vld_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_wr_q   <= ram_wr_d;
        end
    end

    // Outputs are computed one state ahead so every pin comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_vld_d    = 1'b0;
        b_vld_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_wr_d   = 1'b0;
        win_b      = B_REQ && (!A_REQ || prio_q);

        case (state_q)
            IDLE: begin
                if (A_REQ || B_REQ) begin
                    owner_d    = win_b;
                    we_d       = win_b ? B_WE : A_WE;
                    ram_addr_d = win_b ? B_ADDR : A_ADDR;
                    ram_din_d  = win_b ? B_WDATA : A_WDATA;
                    ram_wr_d   = win_b ? B_WE : A_WE;
                    a_gnt_d    = !win_b;
                    b_gnt_d    = win_b;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                prio_d  = !owner_q;
                cnt_d   = CW'(RD_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) b_rdata_d = RAM_DATA_OUT;
                        else         a_rdata_d = RAM_DATA_OUT;
                    end
                    a_vld_d = !owner_q;
                    b_vld_d = owner_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign A_GNT       = a_gnt_q;
    assign B_GNT       = b_gnt_q;
    assign A_VALID     = a_vld_q;
    assign B_VALID     = b_vld_q;
    assign A_RDATA     = a_rdata_q;
    assign B_RDATA     = b_rdata_q;
    assign RAM_ADDR    = ram_addr_q;
    assign RAM_DATA_IN = ram_din_q;
    assign RAM_WRITE   = ram_wr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: behavioural RAMs at latency 1 (main DUT) and 3 (second DUT).
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       A_REQ, A_WE, B_REQ, B_WE;
    logic [4:0] A_ADDR, B_ADDR;
    logic [7:0] A_WDATA, B_WDATA;
    logic       A_GNT, A_VALID, B_GNT, B_VALID;
    logic [7:0] A_RDATA, B_RDATA;
    logic [4:0] RAM_ADDR;
    logic [7:0] RAM_DATA_IN, RAM_DATA_OUT;
    logic       RAM_WRITE;

    logic       C_A_REQ, C_A_WE, C_B_REQ, C_B_WE;
    logic [4:0] C_A_ADDR, C_B_ADDR;
    logic [7:0] C_A_WDATA, C_B_WDATA;
    logic       C_A_GNT, C_A_VALID, C_B_GNT, C_B_VALID;
    logic [7:0] C_A_RDATA, C_B_RDATA;
    logic [4:0] C_RAM_ADDR;
    logic [7:0] C_RAM_DATA_IN, C_RAM_DATA_OUT;
    logic       C_RAM_WRITE;

    logic [7:0] mem  [32];
    logic [7:0] mem2 [32];
    logic [7:0] p1, p2;

    int tests_run = 0;
    int fails = 0;

    ram_port_arbiter #(.ADDR_BITS(5), .DATA_BITS(8), .RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_GNT(A_GNT), .A_RDATA(A_RDATA), .A_VALID(A_VALID),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_GNT(B_GNT), .B_RDATA(B_RDATA), .B_VALID(B_VALID),
        .RAM_ADDR(RAM_ADDR), .RAM_DATA_IN(RAM_DATA_IN),
        .RAM_WRITE(RAM_WRITE), .RAM_DATA_OUT(RAM_DATA_OUT)
    );

    ram_port_arbiter #(.ADDR_BITS(5), .DATA_BITS(8), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .A_REQ(C_A_REQ), .A_WE(C_A_WE), .A_ADDR(C_A_ADDR), .A_WDATA(C_A_WDATA),
        .A_GNT(C_A_GNT), .A_RDATA(C_A_RDATA), .A_VALID(C_A_VALID),
        .B_REQ(C_B_REQ), .B_WE(C_B_WE), .B_ADDR(C_B_ADDR), .B_WDATA(C_B_WDATA),
        .B_GNT(C_B_GNT), .B_RDATA(C_B_RDATA), .B_VALID(C_B_VALID),
        .RAM_ADDR(C_RAM_ADDR), .RAM_DATA_IN(C_RAM_DATA_IN),
        .RAM_WRITE(C_RAM_WRITE), .RAM_DATA_OUT(C_RAM_DATA_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]  = 8'h00;
            mem2[i] = 8'h00;
        end
        mem[0]  = 8'h80;
        mem[1]  = 8'h3E;
        mem2[0] = 8'h80;
    end

    // Latency-1 RAM for the main DUT
    always @(posedge clk) begin
        if (RAM_WRITE) mem[RAM_ADDR] <= RAM_DATA_IN;
        RAM_DATA_OUT <= mem[RAM_ADDR];
    end

    // Latency-3 RAM for the second DUT
    always @(posedge clk) begin
        if (C_RAM_WRITE) mem2[C_RAM_ADDR] <= C_RAM_DATA_IN;
        p1             <= mem2[C_RAM_ADDR];
        p2             <= p1;
        C_RAM_DATA_OUT <= p2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int wr;
        int gn;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({A_GNT, B_GNT, A_VALID, B_VALID, RAM_WRITE} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000", {A_GNT, B_GNT, A_VALID, B_VALID, RAM_WRITE});
        end
        tests_run++;
        if ({RAM_ADDR, RAM_DATA_IN, A_RDATA, B_RDATA} !== 29'b0) begin
            fails++; $display("FAIL reset_data: addr %h din %h ardata %h brdata %h want all 0", RAM_ADDR, RAM_DATA_IN, A_RDATA, B_RDATA);
        end
        rst_n = 1'b1;
        wr = 0;
        gn = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            wr += int'(RAM_WRITE);
            gn += int'(A_GNT) + int'(B_GNT) + int'(A_VALID) + int'(B_VALID);
        end
        tests_run++;
        if (wr !== 0 || gn !== 0) begin
            fails++; $display("FAIL idle_quiet: write pulses %0d handshake pulses %0d want 0 0", wr, gn);
        end
    endtask

    task automatic test_single_read;
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd1; A_WDATA = 8'h00;
        tick();
        tests_run++;
        if ({A_GNT, B_GNT, RAM_WRITE} !== 3'b100 || RAM_ADDR !== 5'd1) begin
            fails++; $display("FAIL rd_grant: gnt/bgnt/wr %b addr %0d want 100 addr 1", {A_GNT, B_GNT, RAM_WRITE}, RAM_ADDR);
        end
        A_REQ = 1'b0;
        tick();
        tests_run++;
        if (A_VALID !== 1'b0) begin
            fails++; $display("FAIL rd_early_valid: got %b want 0", A_VALID);
        end
        tick();
        tests_run++;
        if (A_VALID !== 1'b1 || A_RDATA !== 8'h3E) begin
            fails++; $display("FAIL rd_valid: valid %b rdata %h want 1 3e", A_VALID, A_RDATA);
        end
        tests_run++;
        if (B_VALID !== 1'b0 || B_RDATA !== 8'h00) begin
            fails++; $display("FAIL rd_b_quiet: bvalid %b brdata %h want 0 00", B_VALID, B_RDATA);
        end
        tick();
        tests_run++;
        if (A_VALID !== 1'b0) begin
            fails++; $display("FAIL rd_valid_pulse: got %b want 0", A_VALID);
        end
    endtask

    task automatic test_write_readback;
        int wr;
        B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 5'd31; B_WDATA = 8'hAA;
        tick();
        wr = int'(RAM_WRITE);
        tests_run++;
        if ({A_GNT, B_GNT, RAM_WRITE} !== 3'b011 || RAM_ADDR !== 5'd31 || RAM_DATA_IN !== 8'hAA) begin
            fails++; $display("FAIL wr_issue: gnt/bgnt/wr %b addr %0d din %h want 011 31 aa", {A_GNT, B_GNT, RAM_WRITE}, RAM_ADDR, RAM_DATA_IN);
        end
        B_REQ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            wr += int'(RAM_WRITE);
            if (k == 1) begin
                tests_run++;
                if (B_VALID !== 1'b1 || B_RDATA !== 8'h00) begin
                    fails++; $display("FAIL wr_ack: bvalid %b brdata %h want 1 00", B_VALID, B_RDATA);
                end
            end
        end
        tests_run++;
        if (wr !== 1 || mem[31] !== 8'hAA) begin
            fails++; $display("FAIL wr_pulse: write cycles %0d mem31 %h want 1 aa", wr, mem[31]);
        end
        B_REQ = 1'b1; B_WE = 1'b0;
        tick();
        tests_run++;
        if (B_GNT !== 1'b1 || RAM_WRITE !== 1'b0) begin
            fails++; $display("FAIL rb_grant: bgnt %b wr %b want 1 0", B_GNT, RAM_WRITE);
        end
        B_REQ = 1'b0;
        tick();
        tick();
        tests_run++;
        if (B_VALID !== 1'b1 || B_RDATA !== 8'hAA || A_RDATA !== 8'h3E) begin
            fails++; $display("FAIL rb_data: bvalid %b brdata %h ardata %h want 1 aa 3e", B_VALID, B_RDATA, A_RDATA);
        end
        tick();
    endtask

    task automatic test_contention;
        logic [3:0] exp;
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd0;
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 5'd1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = {(i == 0 || i == 8), (i == 4 || i == 12), (i == 2 || i == 10), (i == 6 || i == 14)};
            tests_run++;
            if ({A_GNT, B_GNT, A_VALID, B_VALID} !== exp) begin
                fails++; $display("FAIL cont_hs cycle %0d: agnt/bgnt/avld/bvld %b want %b", i + 1, {A_GNT, B_GNT, A_VALID, B_VALID}, exp);
            end
            if (i == 2) begin
                tests_run++;
                if (A_RDATA !== 8'h80 || B_RDATA !== 8'hAA) begin
                    fails++; $display("FAIL cont_a_data: ardata %h brdata %h want 80 aa", A_RDATA, B_RDATA);
                end
            end
            if (i == 6) begin
                tests_run++;
                if (A_RDATA !== 8'h80 || B_RDATA !== 8'h3E) begin
                    fails++; $display("FAIL cont_b_data: ardata %h brdata %h want 80 3e", A_RDATA, B_RDATA);
                end
            end
        end
        A_REQ = 1'b0;
        B_REQ = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        // An A read first leaves PRIO pointing at B, so a correct reset is visible.
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd0;
        tick();
        A_REQ = 1'b0;
        repeat (3) tick();
        A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 5'd5; A_WDATA = 8'h55;
        tick();
        tests_run++;
        if (A_GNT !== 1'b1 || RAM_WRITE !== 1'b1) begin
            fails++; $display("FAIL abort_issue: agnt %b wr %b want 1 1", A_GNT, RAM_WRITE);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (RAM_WRITE !== 1'b0 || A_GNT !== 1'b0) begin
            fails++; $display("FAIL abort_async: wr %b agnt %b want 0 0", RAM_WRITE, A_GNT);
        end
        A_REQ = 1'b0; A_WE = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if ({A_VALID, B_VALID, RAM_WRITE} !== 3'b000) begin
                fails++; $display("FAIL abort_no_valid cycle %0d: avld/bvld/wr %b want 000", k, {A_VALID, B_VALID, RAM_WRITE});
            end
        end
        tests_run++;
        if (mem[5] !== 8'h00) begin
            fails++; $display("FAIL abort_mem: mem5 %h want 00", mem[5]);
        end
        A_REQ = 1'b1; A_ADDR = 5'd0;
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 5'd1;
        tick();
        tests_run++;
        if ({A_GNT, B_GNT} !== 2'b10) begin
            fails++; $display("FAIL abort_prio: agnt/bgnt %b want 10", {A_GNT, B_GNT});
        end
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_latency3;
        C_A_REQ = 1'b1; C_A_WE = 1'b0; C_A_ADDR = 5'd0;
        tick();
        tests_run++;
        if (C_A_GNT !== 1'b1) begin
            fails++; $display("FAIL lat3_grant: got %b want 1", C_A_GNT);
        end
        C_A_REQ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (C_A_VALID !== (k == 3)) begin
                fails++; $display("FAIL lat3_valid cycle %0d: got %b want %b", k + 2, C_A_VALID, (k == 3));
            end
            if (k == 2) begin
                tests_run++;
                if (C_A_RDATA !== 8'h00) begin
                    fails++; $display("FAIL lat3_early_data: got %h want 00", C_A_RDATA);
                end
            end
            if (k == 3) begin
                tests_run++;
                if (C_A_RDATA !== 8'h80) begin
                    fails++; $display("FAIL lat3_data: got %h want 80", C_A_RDATA);
                end
            end
        end
        tick();
        tests_run++;
        if (C_A_VALID !== 1'b0) begin
            fails++; $display("FAIL lat3_pulse: got %b want 0", C_A_VALID);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = '0; A_WDATA = '0;
        B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = '0; B_WDATA = '0;
        C_A_REQ = 1'b0; C_A_WE = 1'b0; C_A_ADDR = '0; C_A_WDATA = '0;
        C_B_REQ = 1'b0; C_B_WE = 1'b0; C_B_ADDR = '0; C_B_WDATA = '0;
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_reset_mid_write();
        test_latency3();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 32x8 RAM (DATA_IN/ADDR/WRITE/DATA_OUT).
- Port A is the processor datapath; port B is the loader/debug path.
- Serialises one access at a time with round-robin fairness, drives the RAM control pins, and returns read data with a valid pulse.

Parameters:
- ADDR_BITS, 5, RAM address width (32 locations).
- DATA_BITS, 8, RAM word width.
- RD_LATENCY, 1, clocks from the RAM address/WRITE being driven to DATA_OUT being valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- A_REQ  in  1  port A request; A_WE, A_ADDR and A_WDATA must be held stable while A_REQ=1 and A_GNT=0.
- A_WE  in  1  1=write, 0=read.
- A_ADDR  in  ADDR_BITS  port A address.
- A_WDATA  in  DATA_BITS  port A write data.
- A_GNT  out  1  one-cycle pulse: port A command accepted.
- A_RDATA  out  DATA_BITS  port A read data; holds its value until the next port A read completes.
- A_VALID  out  1  one-cycle pulse: port A access complete (A_RDATA valid if read).
- B_REQ, B_WE, B_ADDR, B_WDATA, B_GNT, B_RDATA, B_VALID: identical to port A, for port B.
- RAM_ADDR  out  ADDR_BITS  to RAM ADDR.
- RAM_DATA_IN  out  DATA_BITS  to RAM DATA_IN.
- RAM_WRITE  out  1  to RAM WRITE.
- RAM_DATA_OUT  in  DATA_BITS  from RAM DATA_OUT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; PRIO=A; GNT/VALID/RAM_WRITE=0; RAM_ADDR, RAM_DATA_IN, A_RDATA, B_RDATA=0.
- All outputs are registered; no combinational path from REQ to GNT.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQ: that port wins.
  - Both REQ: the port named by PRIO wins.
  - On a win, latch WE/ADDR/WDATA and the owner, then go to ISSUE.
- ISSUE (1 cycle):
  - Owner GNT=1; RAM_ADDR/RAM_DATA_IN = latched values.
  - RAM_WRITE=1 only if latched WE=1.
  - PRIO toggles to the non-owner.
  - Next state: WAIT.
- WAIT (RD_LATENCY cycles, counter):
  - RAM_WRITE=0.
  - At the end of the last WAIT cycle, if read: owner RDATA <= RAM_DATA_OUT.
  - Next state: DONE.
- DONE (1 cycle): owner VALID=1; next state: IDLE.
- Writes follow the same path as reads: VALID is the write acknowledge; RDATA is unchanged.
- Timing, RD_LATENCY=1, with REQ sampled at edge 0:
  - GNT and RAM_WRITE in cycle 1.
  - VALID in cycle 3.
  - IDLE in cycle 4, which can accept the next request.
  - Throughput is one access per 3+RD_LATENCY cycles.
- RAM_ADDR and RAM_DATA_IN hold their last values after an access; RAM_WRITE is high for exactly one cycle per write.
- Requester rules:
  - Deassert REQ no later than the cycle after GNT.
  - REQ still high when the arbiter returns to IDLE is treated as a new request.
  - REQ raised while the arbiter is busy waits; it is not lost.
- The non-owner's GNT, VALID and RDATA are never disturbed by the owner's transaction.
- Reset mid-transaction:
  - Aborts immediately; RAM_WRITE drops asynchronously.
  - No VALID is issued for the aborted access.
  - PRIO returns to A.
- Address wrap: none needed; the full ADDR_BITS range (0..31) is passed through unmodified.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, no REQ → all outputs 0, RAM_WRITE never pulses over 10 cycles.
- Single read, RAM pre-initialised RAM[1]=0x3E:
  - A_REQ, A_WE=0, A_ADDR=1 → A_GNT in cycle 1, RAM_ADDR=1, A_VALID in cycle 3, A_RDATA=0x3E.
  - B_VALID stays 0 and B_RDATA stays 0.
- Write then read-back:
  - B writes 0xAA to addr 31 → RAM_WRITE=1 for exactly one cycle with RAM_ADDR=31 and RAM_DATA_IN=0xAA; B_VALID pulses.
  - B then reads addr 31 → B_RDATA=0xAA.
- Contention, both REQ held continuously:
  - Grant order is A, B, A, B.
  - A reads addr 0 (0x80); B reads addr 1 (0x3E).
  - A_RDATA=0x80 and B_RDATA=0x3E, with no cross-talk between ports.
- Reset mid-write: A writes 0x55 to addr 5, and rst_n falls during ISSUE → RAM_WRITE falls immediately, no A_VALID, state returns to IDLE, next simultaneous request grants A.
- RD_LATENCY=3 build: single read of addr 0 → A_VALID five cycles after GNT-cycle start (cycle 5), A_RDATA=0x80.
